// File: rtl/tod_pkg.sv
// Shared widths, hour constants and the 24h -> 12h display mapping for the
// time-of-day counter.
package tod_pkg;

    localparam int SEC_W  = 6;
    localparam int MIN_W  = 6;
    localparam int HOUR_W = 5;

    localparam logic [HOUR_W-1:0] HOUR24_MAX  = 5'd23;
    localparam logic [HOUR_W-1:0] HOUR12_NOON = 5'd12;

    // 12-hour display value: hour24 % 12, with 0 shown as 12.
    function automatic logic [HOUR_W-1:0] hour24_to_12(input logic [HOUR_W-1:0] h24);
        logic [HOUR_W-1:0] h;
        h = (h24 >= HOUR12_NOON) ? h24 - HOUR12_NOON : h24;
        return (h == '0) ? HOUR12_NOON : h;
    endfunction

endpackage

// File: rtl/time_of_day_counter_if.sv
// Load/readout bus of the time-of-day counter. The alarm signals exist only
// when TOD_ALARM_EN is defined.
//
// Handshake: set_valid and alarm_set are single-cycle strobes with no ready.
// The core accepts or rejects every strobe in the cycle it is sampled; a
// rejection shows up as a one-cycle set_err pulse on the following cycle.
interface time_of_day_counter_if;
    import tod_pkg::*;

    logic              set_valid;
    logic [HOUR_W-1:0] set_hour;
    logic [MIN_W-1:0]  set_minute;
    logic [SEC_W-1:0]  set_second;
    logic              set_err;
    logic [SEC_W-1:0]  second;
    logic [MIN_W-1:0]  minute;
    logic [HOUR_W-1:0] hour;
    logic              pm;
    logic              sec_tick;
    logic              new_day;
`ifdef TOD_ALARM_EN
    logic              alarm_set;
    logic [HOUR_W-1:0] alarm_hour;
    logic [MIN_W-1:0]  alarm_minute;
    logic              alarm_arm;
    logic              alarm_fire;
`endif

    modport master (
        output set_valid, set_hour, set_minute, set_second,
`ifdef TOD_ALARM_EN
        output alarm_set, alarm_hour, alarm_minute, alarm_arm,
        input  alarm_fire,
`endif
        input  set_err, second, minute, hour, pm, sec_tick, new_day
    );

    modport slave (
        input  set_valid, set_hour, set_minute, set_second,
`ifdef TOD_ALARM_EN
        input  alarm_set, alarm_hour, alarm_minute, alarm_arm,
        output alarm_fire,
`endif
        output set_err, second, minute, hour, pm, sec_tick, new_day
    );

endinterface

// File: rtl/tod_prescaler.sv
// Divides clk down to a one-cycle second tick. Counts only while run is high;
// clr restarts the count from zero (used by a time load).
module tod_prescaler #(
    parameter int DIV = 50_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic clr,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] count;

    assign tick = run && (count == LAST);

    // Cycle counter: wraps at DIV-1, holds while stopped, clr has priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (run) begin
            count <= (count == LAST) ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/time_of_day_counter.sv
// hh:mm:ss time-of-day counter with prescaler, run enable, validated load,
// runtime 12/24-hour display and registered sec_tick/new_day pulses.
// Optional alarm compare is built when TOD_ALARM_EN is defined.
module time_of_day_counter
    import tod_pkg::*;
#(
    parameter int DIV     = 50_000_000,
    parameter int SEC_MAX = 59,
    parameter int MIN_MAX = 59
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic mode_24h,
    time_of_day_counter_if.slave bus
);

    localparam logic [SEC_W-1:0] SEC_LAST = SEC_W'(SEC_MAX);
    localparam logic [MIN_W-1:0] MIN_LAST = MIN_W'(MIN_MAX);

    logic [SEC_W-1:0]  sec_q, sec_nx;
    logic [MIN_W-1:0]  min_q, min_nx;
    logic [HOUR_W-1:0] hour_q, hour_nx;
    logic              tick, load_ok, load_bad, advance, day_wrap;
    logic              sec_wrap, min_wrap;
    logic              sec_tick_q, new_day_q, set_err_q;
    logic              alarm_bad;

    tod_prescaler #(.DIV(DIV)) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .run   (run),
        .clr   (load_ok),
        .tick  (tick)
    );

    // Load range check and the successor time for one second advance.
    always_comb begin
        load_ok  = bus.set_valid && (bus.set_hour <= HOUR24_MAX) &&
                   (bus.set_minute <= MIN_LAST) && (bus.set_second <= SEC_LAST);
        load_bad = bus.set_valid && !load_ok;
        advance  = tick && !load_ok;
        sec_wrap = (sec_q == SEC_LAST);
        min_wrap = (min_q == MIN_LAST);
        day_wrap = sec_wrap && min_wrap && (hour_q == HOUR24_MAX);
        sec_nx   = sec_wrap ? '0 : sec_q + 1'b1;
        min_nx   = min_q;
        hour_nx  = hour_q;
        if (sec_wrap) begin
            min_nx = min_wrap ? '0 : min_q + 1'b1;
            if (min_wrap) begin
                hour_nx = (hour_q == HOUR24_MAX) ? '0 : hour_q + 1'b1;
            end
        end
    end

    // Time registers: a valid load wins over a coincident tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sec_q  <= '0;
            min_q  <= '0;
            hour_q <= '0;
        end else if (load_ok) begin
            sec_q  <= bus.set_second;
            min_q  <= bus.set_minute;
            hour_q <= bus.set_hour;
        end else if (advance) begin
            sec_q  <= sec_nx;
            min_q  <= min_nx;
            hour_q <= hour_nx;
        end
    end

    // One-cycle status pulses, aligned with the new time becoming visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sec_tick_q <= 1'b0;
            new_day_q  <= 1'b0;
            set_err_q  <= 1'b0;
        end else begin
            sec_tick_q <= advance;
            new_day_q  <= advance && day_wrap;
            set_err_q  <= load_bad || alarm_bad;
        end
    end

`ifdef TOD_ALARM_EN
    logic [HOUR_W-1:0] alarm_hour_q;
    logic [MIN_W-1:0]  alarm_min_q;
    logic              alarm_fire_q, alarm_ok, alarm_hit;

    // Alarm range check and match against the time being advanced into.
    always_comb begin
        alarm_ok  = (bus.alarm_hour <= HOUR24_MAX) && (bus.alarm_minute <= MIN_LAST);
        alarm_bad = bus.alarm_set && !alarm_ok;
        alarm_hit = bus.alarm_arm && (sec_nx == '0) &&
                    (min_nx == alarm_min_q) && (hour_nx == alarm_hour_q);
    end

    // Alarm time latch and fire pulse; loads never fire.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alarm_hour_q <= '0;
            alarm_min_q  <= '0;
            alarm_fire_q <= 1'b0;
        end else begin
            if (bus.alarm_set && alarm_ok) begin
                alarm_hour_q <= bus.alarm_hour;
                alarm_min_q  <= bus.alarm_minute;
            end
            alarm_fire_q <= advance && alarm_hit;
        end
    end

    assign bus.alarm_fire = alarm_fire_q;
`else
    assign alarm_bad = 1'b0;
`endif

    assign bus.second   = sec_q;
    assign bus.minute   = min_q;
    assign bus.hour     = mode_24h ? hour_q : hour24_to_12(hour_q);
    assign bus.pm       = (hour_q >= HOUR12_NOON);
    assign bus.sec_tick = sec_tick_q;
    assign bus.new_day  = new_day_q;
    assign bus.set_err  = set_err_q;

endmodule

// File: tb/tb_time_of_day_counter.sv
// Bench for time_of_day_counter (DIV=4). A seconds-of-day model predicts every
// cycle's outputs; directed sequences pin known values; a random phase follows.
// Define TOD_ALARM_EN to also exercise the alarm.
module tb_time_of_day_counter;

    localparam int DIV     = 4;
    localparam int SEC_MAX = 59;
    localparam int MIN_MAX = 59;
    localparam int SPM     = SEC_MAX + 1;
    localparam int SPH     = SPM * (MIN_MAX + 1);
    localparam int DAY     = SPH * 24;

    typedef struct packed {
        logic [5:0] sec;
        logic [5:0] min;
        logic [4:0] h24;
        logic       tick;
        logic       nd;
        logic       err;
        logic       fire;
    } exp_t;
    localparam int W = $bits(exp_t);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic run = 1'b0;
    logic mode_24h = 1'b1;

    time_of_day_counter_if bus ();

    time_of_day_counter #(.DIV(DIV), .SEC_MAX(SEC_MAX), .MIN_MAX(MIN_MAX)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .run      (run),
        .mode_24h (mode_24h),
        .bus      (bus)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;
    logic [W-1:0] exp_q[$];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int t_mod = 0;
    int p_mod = 0;
    int ah_mod = 0;
    int am_mod = 0;

    always @(posedge clk) begin
        exp_t e;
        bit   ok, tk;
        e = '0;
        if (!rst_n) begin
            t_mod = 0; p_mod = 0; ah_mod = 0; am_mod = 0;
        end else begin
            ok = (int'(bus.set_hour) <= 23) && (int'(bus.set_minute) <= MIN_MAX) &&
                 (int'(bus.set_second) <= SEC_MAX);
            tk = run && (p_mod == DIV - 1);
            if (run) p_mod = (p_mod == DIV - 1) ? 0 : p_mod + 1;
            if (bus.set_valid && ok) begin
                t_mod = int'(bus.set_hour) * SPH + int'(bus.set_minute) * SPM + int'(bus.set_second);
                p_mod = 0;
            end else begin
                e.err = bus.set_valid;
                if (tk) begin
                    t_mod  = (t_mod + 1) % DAY;
                    e.tick = 1'b1;
                    e.nd   = (t_mod == 0);
`ifdef TOD_ALARM_EN
                    e.fire = bus.alarm_arm && (t_mod == ah_mod * SPH + am_mod * SPM);
`endif
                end
            end
`ifdef TOD_ALARM_EN
            if (bus.alarm_set) begin
                if (int'(bus.alarm_hour) <= 23 && int'(bus.alarm_minute) <= MIN_MAX) begin
                    ah_mod = int'(bus.alarm_hour);
                    am_mod = int'(bus.alarm_minute);
                end else begin
                    e.err = 1'b1;
                end
            end
`endif
        end
        e.sec = 6'(t_mod % SPM);
        e.min = 6'((t_mod / SPM) % (MIN_MAX + 1));
        e.h24 = 5'(t_mod / SPH);
        exp_q.push_back(e);
    end

    // ---------------- scoreboard compare ----------------
    always @(posedge clk) begin
        exp_t e;
        int   h;
        #3;
        if (exp_q.size() == 0) begin
            chk("exp_q_empty", 1, 0);
        end else begin
            e = exp_t'(exp_q.pop_front());
            h = mode_24h ? int'(e.h24) : ((int'(e.h24) % 12 == 0) ? 12 : int'(e.h24) % 12);
            chk("second",   int'(bus.second),   int'(e.sec));
            chk("minute",   int'(bus.minute),   int'(e.min));
            chk("hour",     int'(bus.hour),     h);
            chk("pm",       int'(bus.pm),       int'(e.h24) >= 12 ? 1 : 0);
            chk("sec_tick", int'(bus.sec_tick), int'(e.tick));
            chk("new_day",  int'(bus.new_day),  int'(e.nd));
            chk("set_err",  int'(bus.set_err),  int'(e.err));
`ifdef TOD_ALARM_EN
            chk("alarm_fire", int'(bus.alarm_fire), int'(e.fire));
`endif
        end
    end

    // ---------------- driver tasks ----------------
    task automatic edges(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load(input int h, input int m, input int s);
        bus.set_valid  = 1'b1;
        bus.set_hour   = 5'(h);
        bus.set_minute = 6'(m);
        bus.set_second = 6'(s);
        edges(1);
        bus.set_valid  = 1'b0;
    endtask

    task automatic chk_time(input string name, input int h, input int m, input int s);
        chk({name, "_hour"},   int'(bus.hour),   h);
        chk({name, "_minute"}, int'(bus.minute), m);
        chk({name, "_second"}, int'(bus.second), s);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int cnt;
        bus.set_valid = 1'b0; bus.set_hour = '0; bus.set_minute = '0; bus.set_second = '0;
`ifdef TOD_ALARM_EN
        bus.alarm_set = 1'b0; bus.alarm_hour = '0; bus.alarm_minute = '0; bus.alarm_arm = 1'b0;
`endif
        edges(2);
        chk_time("reset", 0, 0, 0);
        chk("reset_pm", int'(bus.pm), 0);
        chk("reset_tick", int'(bus.sec_tick), 0);
        rst_n = 1'b1;
        run = 1'b1;

        // Free run from reset: ticks on edges 4, 8, 12.
        cnt = 0;
        repeat (12) begin
            edges(1);
            cnt += int'(bus.sec_tick);
        end
        chk("run12_ticks", cnt, 3);
        chk_time("run12", 0, 0, 3);

        // Midnight wrap.
        load(23, 59, 58);
        chk_time("ld_2359", 23, 59, 58);
        chk("ld_2359_pm", int'(bus.pm), 1);
        edges(4);
        chk_time("t_235959", 23, 59, 59);
        chk("t_235959_tick", int'(bus.sec_tick), 1);
        edges(3);
        chk("pre_wrap_nd", int'(bus.new_day), 0);
        edges(1);
        chk_time("wrap", 0, 0, 0);
        chk("wrap_nd", int'(bus.new_day), 1);
        chk("wrap_pm", int'(bus.pm), 0);
        edges(1);
        chk("post_wrap_nd", int'(bus.new_day), 0);

        // 12-hour display mapping.
        run = 1'b0;
        mode_24h = 1'b0;
        load(0, 0, 0);
        chk("h12_00", int'(bus.hour), 12);
        chk("h12_00_pm", int'(bus.pm), 0);
        load(12, 0, 0);
        chk("h12_12", int'(bus.hour), 12);
        chk("h12_12_pm", int'(bus.pm), 1);
        load(13, 25, 40);
        chk_time("h12_13", 1, 25, 40);
        chk("h12_13_pm", int'(bus.pm), 1);
        #1 mode_24h = 1'b1;
        #1 chk_time("h24_13", 13, 25, 40);

        // Rejected loads.
        load(10, 20, 30);
        load(24, 0, 0);
        chk("err_h24", int'(bus.set_err), 1);
        chk_time("err_h24", 10, 20, 30);
        edges(1);
        chk("err_clear", int'(bus.set_err), 0);
        load(10, 60, 0);
        chk("err_m60", int'(bus.set_err), 1);
        chk_time("err_m60", 10, 20, 30);

        // Load on a tick edge: load wins, tick dropped, prescaler restarts.
        run = 1'b1;
        load(1, 2, 3);
        edges(3);
        load(10, 20, 30);
        chk_time("ld_on_tick", 10, 20, 30);
        chk("ld_on_tick_tick", int'(bus.sec_tick), 0);
        edges(3);
        chk("ld_next_early", int'(bus.sec_tick), 0);
        edges(1);
        chk("ld_next_tick", int'(bus.sec_tick), 1);
        chk_time("ld_next", 10, 20, 31);

        // Frozen time.
        run = 1'b0;
        cnt = 0;
        repeat (10) begin
            edges(1);
            cnt += int'(bus.sec_tick);
        end
        chk("frozen_ticks", cnt, 0);
        chk_time("frozen", 10, 20, 31);
        run = 1'b1;
        edges(6);

        // Asynchronous reset, checked before any clock edge.
        #2 rst_n = 1'b0;
        #1 chk_time("async_rst", 0, 0, 0);
        chk("async_rst_tick", int'(bus.sec_tick), 0);
        edges(1);
        rst_n = 1'b1;

`ifdef TOD_ALARM_EN
        bus.alarm_set = 1'b1; bus.alarm_hour = 5'd7; bus.alarm_minute = 6'd30;
        bus.alarm_arm = 1'b1;
        edges(1);
        bus.alarm_set = 1'b0;
        load(7, 29, 59);
        edges(4);
        chk("alarm_fire", int'(bus.alarm_fire), 1);
        chk_time("alarm", 7, 30, 0);
        load(7, 30, 0);
        chk("alarm_on_load", int'(bus.alarm_fire), 0);
        bus.alarm_arm = 1'b0;
        load(7, 29, 59);
        edges(4);
        chk("alarm_disarmed", int'(bus.alarm_fire), 0);
        chk_time("alarm_disarmed", 7, 30, 0);
`endif

        // Random phase, checked by the model every cycle.
        repeat (600) begin
            run      = ($urandom_range(0, 9) != 0);
            mode_24h = $urandom_range(0, 1) == 1;
            bus.set_valid = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 1) == 1) begin
                bus.set_hour   = 5'd23;
                bus.set_minute = 6'd59;
                bus.set_second = 6'($urandom_range(50, 59));
            end else begin
                bus.set_hour   = 5'($urandom_range(0, 31));
                bus.set_minute = 6'($urandom_range(0, 63));
                bus.set_second = 6'($urandom_range(0, 63));
            end
`ifdef TOD_ALARM_EN
            bus.alarm_set    = ($urandom_range(0, 49) == 0);
            bus.alarm_hour   = ($urandom_range(0, 1) == 1) ? 5'd0 : 5'($urandom_range(0, 31));
            bus.alarm_minute = ($urandom_range(0, 1) == 1) ? 6'd0 : 6'($urandom_range(0, 63));
            bus.alarm_arm    = ($urandom_range(0, 3) != 0);
`endif
            edges(1);
        end
        bus.set_valid = 1'b0;
`ifdef TOD_ALARM_EN
        bus.alarm_set = 1'b0;
`endif
        edges(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
